// File: rtl/rv32_ctrl_pkg.sv
// Shared types and constants for the RV32 multi-cycle sequencer.
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } seq_state_t;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam int unsigned PC_STEP     = 4;
    localparam int unsigned REG_AW      = 5;

endpackage

// File: rtl/rv32_seq_perf.sv
// Retired-instruction and fetch-stall counters for the RV32 sequencer.
// Both counters wrap at 2^32 and clear synchronously on clear_i.
module rv32_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        retire_i,
    input  logic        stall_i,
    output logic [31:0] retired_o,
    output logic [31:0] stall_cycles_o
);

    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;

    // Next-state: clear wins over counting.
    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (clear_i) begin
            retired_d = '0;
            stall_d   = '0;
        end else begin
            if (retire_i) retired_d = retired_q + 32'd1;
            if (stall_i)  stall_d   = stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_o      = retired_q;
    assign stall_cycles_o = stall_q;

endmodule

// File: rtl/rv32_seq_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH -> DECODE -> EXEC -> WB, halting on EBREAK.
// Optional performance counters are enabled by defining RV32_SEQ_PERF_CNT_EN.
module rv32_seq_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              imem_req_o,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              imem_valid_i,
    output logic [31:0]       inst_o,
    input  logic [REG_AW-1:0] dec_rd_i,
    input  logic              dec_w_en_i,
    input  logic [XLEN-1:0]   alu_result_i,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [XLEN-1:0]   rf_wdata_o,
    output logic [XLEN-1:0]   pc_o,
    output logic              busy_o,
    output logic              halted_o
`ifdef RV32_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       retired_o,
    output logic [31:0]       stall_cycles_o
`endif
);

    seq_state_t        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic              we_q, we_d;
    logic              restart;

    // Next-state and datapath register updates for the instruction sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        res_d   = res_q;
        waddr_d = waddr_q;
        we_d    = we_q;
        restart = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StFetch;
            end
            StFetch: begin
                if (imem_valid_i) begin
                    inst_d  = imem_rdata_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = (inst_q == INST_EBREAK) ? StHalt : StExec;
            end
            StExec: begin
                res_d   = alu_result_i;
                waddr_d = dec_rd_i;
                // x0 is hardwired to zero, so its writes never leave the sequencer.
                we_d    = dec_w_en_i && (dec_rd_i != '0);
                state_d = StWb;
            end
            StWb: begin
                pc_d    = pc_q + XLEN'(PC_STEP);
                state_d = StFetch;
            end
            StHalt: begin
                if (start_i) begin
                    pc_d    = RESET_PC;
                    restart = 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            res_q   <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            res_q   <= res_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
        end
    end

    // Outputs come from registers or the state alone.
    assign imem_req_o  = (state_q == StFetch);
    assign imem_addr_o = pc_q;
    assign inst_o      = inst_q;
    assign rf_we_o     = (state_q == StWb) && we_q;
    assign rf_waddr_o  = waddr_q;
    assign rf_wdata_o  = res_q;
    assign pc_o        = pc_q;
    assign busy_o      = (state_q != StIdle) && (state_q != StHalt);
    assign halted_o    = (state_q == StHalt);

`ifdef RV32_SEQ_PERF_CNT_EN
    rv32_seq_perf u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (restart),
        .retire_i       (state_q == StWb),
        .stall_i        ((state_q == StFetch) && !imem_valid_i),
        .retired_o      (retired_o),
        .stall_cycles_o (stall_cycles_o)
    );
`endif

endmodule
